// File: rtl/pwm_cfg_pkg.sv
// Shared constants and FSM state type for the SPI-to-PWM configuration path.
package pwm_cfg_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  localparam int unsigned FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous input with a history flop
// providing single-cycle rise/fall pulses on the synchronised level.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_pwm_cfg_ctrl.sv
// SPI mode-0 write-only target that commits 16-bit frames into the PWM
// configuration registers, counting malformed frames in a saturating counter.
module spi_pwm_cfg_ctrl
  import pwm_cfg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             copi,
  input  logic             ncs,
  output logic [7:0]       en_reg_out_7_0,
  output logic [7:0]       en_reg_out_15_8,
  output logic [7:0]       en_reg_pwm_7_0,
  output logic [7:0]       en_reg_pwm_15_8,
  output logic [7:0]       pwm_duty_cycle,
  output logic             wr_strobe,
  output logic [6:0]       wr_addr,
  output logic [ERR_W-1:0] err_count
);

  logic sclk_level, sclk_rise, sclk_fall;
  logic copi_level, copi_rise, copi_fall;
  logic ncs_level, ncs_rise, ncs_fall;
  logic unused_edges;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst(rst), .din(copi),
    .level(copi_level), .rise(copi_rise), .fall(copi_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst(rst), .din(ncs),
    .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
  );

  assign unused_edges = ^{sclk_level, sclk_fall, copi_rise, copi_fall, ncs_level};

  state_t      state;
  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic        ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      shift_reg       <= '0;
      bit_cnt         <= '0;
      ovf             <= 1'b0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
      wr_strobe       <= 1'b0;
      wr_addr         <= '0;
      err_count       <= '0;
    end else begin
      wr_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (ncs_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            ovf     <= 1'b0;
          end
        end
        SHIFT: begin
          // ncs rise takes priority so a coincident sclk edge is never shifted
          if (ncs_rise) begin
            if (bit_cnt != 5'(FRAME_BITS) || ovf) begin
              if (err_count != '1) err_count <= err_count + 1'b1;
              state <= IDLE;
            end else if (shift_reg[15] && (shift_reg[14:8] < 7'(NUM_REGS))) begin
              state <= COMMIT;
            end else begin
              state <= IDLE;
            end
          end else if (sclk_rise) begin
            shift_reg <= {shift_reg[14:0], copi_level};
            if (bit_cnt < 5'(FRAME_BITS)) bit_cnt <= bit_cnt + 1'b1;
            else                          ovf     <= 1'b1;
          end
        end
        COMMIT: begin
          case (shift_reg[14:8])
            ADDR_EN_OUT_LO: en_reg_out_7_0  <= shift_reg[7:0];
            ADDR_EN_OUT_HI: en_reg_out_15_8 <= shift_reg[7:0];
            ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= shift_reg[7:0];
            ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= shift_reg[7:0];
            ADDR_DUTY:      pwm_duty_cycle  <= shift_reg[7:0];
            default: ;
          endcase
          wr_strobe <= 1'b1;
          wr_addr   <= shift_reg[14:8];
          if (ncs_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            ovf     <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_pwm_cfg_ctrl.sv
// Self-checking bench for spi_pwm_cfg_ctrl: table of SPI frames plus hand
// sequences for reset-mid-frame and error-counter saturation.
module tb_spi_pwm_cfg_ctrl;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned ERR_W       = 8;
  localparam int unsigned HALF        = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sclk = 1'b0;
  logic             copi = 1'b0;
  logic             ncs = 1'b1;
  logic [7:0]       en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic             wr_strobe;
  logic [6:0]       wr_addr;
  logic [ERR_W-1:0] err_count;

  spi_pwm_cfg_ctrl #(.SYNC_STAGES(SYNC_STAGES), .NUM_REGS(5), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] bits;
    int unsigned nbits;
    logic        wr;
    logic [7:0]  err;
    int unsigned gap;
  } vec_t;

  int unsigned applied = 0;
  int unsigned miscompares = 0;
  int unsigned strobes = 0;
  wr_t         sb_q[$];
  logic [7:0]  mdl[5];
  logic [7:0]  exp_err;

  function automatic logic [7:0] dut_reg(input logic [6:0] a);
    case (a)
      7'h00: return en_reg_out_7_0;
      7'h01: return en_reg_out_15_8;
      7'h02: return en_reg_pwm_7_0;
      7'h03: return en_reg_pwm_15_8;
      7'h04: return pwm_duty_cycle;
      default: return 8'hxx;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name);
    chk({name, "_out_lo"}, 32'(en_reg_out_7_0), 32'(mdl[0]));
    chk({name, "_out_hi"}, 32'(en_reg_out_15_8), 32'(mdl[1]));
    chk({name, "_pwm_lo"}, 32'(en_reg_pwm_7_0), 32'(mdl[2]));
    chk({name, "_pwm_hi"}, 32'(en_reg_pwm_15_8), 32'(mdl[3]));
    chk({name, "_duty"}, 32'(pwm_duty_cycle), 32'(mdl[4]));
    chk({name, "_err"}, 32'(err_count), 32'(exp_err));
    chk({name, "_sb_empty"}, sb_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && wr_strobe) begin
      wr_t w;
      strobes++;
      applied++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: got wr_addr %0h expected no strobe", wr_addr);
      end else begin
        w = sb_q.pop_front();
        if (wr_addr !== w.addr || dut_reg(w.addr) !== w.data) begin
          miscompares++;
          $display("FAIL strobe_write: got addr %0h data %0h expected addr %0h data %0h",
                   wr_addr, dut_reg(w.addr), w.addr, w.data);
        end
      end
    end
  end

  task automatic shift_bits(input logic [31:0] bits, input int unsigned n);
    for (int i = int'(n) - 1; i >= 0; i--) begin
      copi = bits[i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  // Drive a whole frame, then check the strobe appears (or not) within the latency bound.
  task automatic send(input logic [31:0] bits, input int unsigned n, input logic exp_wr,
                      input int unsigned gap);
    logic seen;
    if (exp_wr) begin
      sb_q.push_back({bits[14:8], bits[7:0]});
      mdl[bits[10:8]] = bits[7:0];
    end
    @(negedge clk);
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    shift_bits(bits, n);
    repeat (HALF) @(negedge clk);
    ncs = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < int'(SYNC_STAGES) + 3; k++) begin
      @(posedge clk);
      #1;
      if (wr_strobe) seen = 1'b1;
    end
    chk("strobe_within_latency", 32'(seen), 32'(exp_wr));
    repeat (gap) @(negedge clk);
  endtask

  vec_t vecs[9];

  initial begin
    int unsigned s0;
    vecs[0] = '{32'h8055,  16, 1'b1, 8'd0, 20};
    vecs[1] = '{32'h8480,  16, 1'b1, 8'd0, 5};
    vecs[2] = '{32'h83F0,  16, 1'b1, 8'd0, 20};
    vecs[3] = '{32'h4012,  15, 1'b0, 8'd1, 20};
    vecs[4] = '{32'h100AA, 17, 1'b0, 8'd2, 20};
    vecs[5] = '{32'h0012,  16, 1'b0, 8'd2, 20};
    vecs[6] = '{32'h8577,  16, 1'b0, 8'd2, 20};
    vecs[7] = '{32'h8123,  16, 1'b1, 8'd2, 20};
    vecs[8] = '{32'h82C3,  16, 1'b1, 8'd2, 20};

    foreach (mdl[i]) mdl[i] = 8'h00;
    exp_err = 8'h00;

    repeat (3) @(negedge clk);
    chk_all("reset");
    chk("reset_strobe", 32'(wr_strobe), 0);
    chk("reset_wr_addr", 32'(wr_addr), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    s0 = strobes;
    for (int v = 0; v < 9; v++) begin
      send(vecs[v].bits, vecs[v].nbits, vecs[v].wr, vecs[v].gap);
      exp_err = vecs[v].err;
      chk_all($sformatf("vec%0d", v));
    end
    chk("table_strobe_count", strobes - s0, 5);

    // Reset while idle with non-zero registers.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    foreach (mdl[i]) mdl[i] = 8'h00;
    exp_err = 8'h00;
    repeat (4) @(negedge clk);
    chk_all("idle_reset");
    chk("idle_reset_wr_addr", 32'(wr_addr), 0);

    // Put a non-zero error count in place, then abort a frame with reset after 8 bits.
    send(32'h1, 3, 1'b0, 10);
    exp_err = 8'h01;
    chk_all("pre_abort");
    @(negedge clk);
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    shift_bits(32'h82, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 8'h00;
    @(negedge clk);
    chk_all("abort_reset");
    chk("abort_reset_strobe", 32'(wr_strobe), 0);
    s0 = strobes;
    shift_bits(32'hAA, 8);
    repeat (HALF) @(negedge clk);
    ncs = 1'b1;
    repeat (20) @(negedge clk);
    chk_all("abort_tail");
    chk("abort_tail_no_strobe", strobes - s0, 0);
    send(32'h82AA, 16, 1'b1, 20);
    chk_all("after_abort");
    chk("after_abort_one_strobe", strobes - s0, 1);

    // Saturation of the error counter.
    for (int f = 0; f < 300; f++) begin
      send(32'h1, 1, 1'b0, 2);
      if (f == 253) chk("err_254", 32'(err_count), 32'hFE);
      if (f == 254) chk("err_255", 32'(err_count), 32'hFF);
    end
    exp_err = 8'hFF;
    chk_all("saturated");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
